// File: rtl/vga_rect_draw_arbiter.sv
// Round-robin arbiter that rasterises one filled rectangle per grant onto the vga_adapter port.
// Optional RECT_CLIP_EN: suppress plot for pixels outside SCREEN_W x SCREEN_H.
module vga_rect_draw_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*7-1:0] req_y,
  input  logic [NUM_REQ*8-1:0] req_w,
  input  logic [NUM_REQ*7-1:0] req_h,
  input  logic [NUM_REQ*3-1:0] req_colour,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  state_t state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, sel_q, sel_d, win;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic               busy_q, busy_d, plot_q, plot_d;
  logic [7:0]         x0_q, x0_d, w_q, w_d, cx_q, cx_d, x_q, x_d;
  logic [6:0]         y0_q, y0_d, h_q, h_d, cy_q, cy_d, y_q, y_d;
  logic [2:0]         col_q, col_d, colour_q, colour_d;

  logic [7:0] slot_x, slot_w, base_x;
  logic [6:0] slot_y, slot_h, base_y;
  logic [2:0] slot_c, base_c;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       emit, in_bounds, found;
  int         idx;

  always_comb begin
    slot_x = req_x[int'(sel_q)*8 +: 8];
    slot_y = req_y[int'(sel_q)*7 +: 7];
    slot_w = req_w[int'(sel_q)*8 +: 8];
    slot_h = req_h[int'(sel_q)*7 +: 7];
    slot_c = req_colour[int'(sel_q)*3 +: 3];
  end

  // First requesting slot at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    plot_d   = 1'b0;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    emit     = 1'b0;
    base_x   = x0_q;
    base_y   = y0_q;
    base_c   = col_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d      = win;
          ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        x0_d  = slot_x;
        y0_d  = slot_y;
        w_d   = slot_w;
        h_d   = slot_h;
        col_d = slot_c;
        cx_d  = '0;
        cy_d  = '0;
        if (slot_w == 8'd0 || slot_h == 7'd0) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          state_d = S_DRAW;
          base_x  = slot_x;
          base_y  = slot_y;
          base_c  = slot_c;
          emit    = 1'b1;
        end
      end
      S_DRAW: begin
        if (cx_q == w_q - 8'd1 && cy_q == h_q - 7'd1) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          if (cx_q == w_q - 8'd1) begin
            cx_d = '0;
            cy_d = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          emit = 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Sums are one bit wider than the outputs so the clip test sees overflow.
    sum_x = {1'b0, base_x} + {1'b0, cx_d};
    sum_y = {1'b0, base_y} + {1'b0, cy_d};
`ifdef RECT_CLIP_EN
    in_bounds = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
`else
    in_bounds = 1'b1;
`endif
    if (emit) begin
      x_d      = sum_x[7:0];
      y_d      = sum_y[6:0];
      colour_d = base_c;
      plot_d   = in_bounds;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      plot_q   <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      plot_q   <= plot_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule
